// File: rtl/snitch_icache_pkg.sv
// Shared definitions for the instruction-cache refill path: the refill ID
// layout (requesting port index above, prefetch flag in the LSB), the output
// stage state encoding and the ID width helper.
package snitch_icache_pkg;

    // Widest port index the ID struct can carry; users slice the low bits.
    localparam int unsigned ID_PORT_W = 8;

    typedef struct packed {
        logic [ID_PORT_W-1:0] port;
        logic                 prefetch;
    } refill_id_t;

    typedef enum logic {
        StEmpty,
        StFull
    } stage_state_e;

    // ID width: enough bits for a port index plus the prefetch flag.
    function automatic int unsigned idw_calc(input int unsigned nr_ports);
        return $clog2(nr_ports) + 1;
    endfunction

endpackage

// File: rtl/snitch_icache_rr_pick.sv
// Round-robin picker. ptr_i holds the index granted last time; the search
// rotates downwards from the port below it and wraps, so the last winner has
// the lowest priority.
module snitch_icache_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // First requester found in rotation order wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!valid_o && req_i[j] && (j == ((32'(ptr_i) + N - k) % N))) begin
                    valid_o  = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/snitch_icache_refill_arbiter.sv
// Refill arbiter: merges per-port L0 refill requests onto one upstream
// channel through a one-entry output register, demand before prefetch with
// separate round-robin pointers, and routes responses back by ID.
// Optional feature macro: SNITCH_ICACHE_ARB_PERF_EN enables the saturating
// performance counters; without it the perf outputs are tied to zero.
module snitch_icache_refill_arbiter
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_PORTS        = 4,
    parameter int unsigned FETCH_AW        = 48,
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned IDW            = idw_calc(NR_PORTS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NR_PORTS-1:0][FETCH_AW-1:0] in_req_addr_i,
    input  logic [NR_PORTS-1:0]               in_req_prefetch_i,
    input  logic [NR_PORTS-1:0]               in_req_valid_i,
    output logic [NR_PORTS-1:0]               in_req_ready_o,
    output logic [LINE_WIDTH-1:0]             in_rsp_data_o,
    output logic                              in_rsp_error_o,
    output logic [NR_PORTS-1:0]               in_rsp_valid_o,
    input  logic [NR_PORTS-1:0]               in_rsp_ready_i,
    output logic [FETCH_AW-1:0]               out_req_addr_o,
    output logic [IDW-1:0]                    out_req_id_o,
    output logic                              out_req_valid_o,
    input  logic                              out_req_ready_i,
    input  logic [LINE_WIDTH-1:0]             out_rsp_data_i,
    input  logic                              out_rsp_error_i,
    input  logic [IDW-1:0]                    out_rsp_id_i,
    input  logic                              out_rsp_valid_i,
    output logic                              out_rsp_ready_o,
    output logic                              misroute_o,
    output logic [31:0]                       perf_demand_o,
    output logic [31:0]                       perf_prefetch_o,
    output logic [31:0]                       perf_conflict_o
);

    localparam int unsigned IW = IDW - 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    stage_state_e                    r_state;
    logic         [FETCH_AW-1:0]     r_addr;
    logic         [IDW-1:0]          r_id;
    logic         [IW-1:0]           r_dem_ptr;
    logic         [IW-1:0]           r_pre_ptr;
    logic         [NR_PORTS-1:0][CW-1:0] r_cnt;

    logic [NR_PORTS-1:0] w_elig;
    logic [NR_PORTS-1:0] w_dem_req;
    logic [NR_PORTS-1:0] w_pre_req;
    logic [NR_PORTS-1:0] w_dem_gnt;
    logic [NR_PORTS-1:0] w_pre_gnt;
    logic [IW-1:0]       w_dem_idx;
    logic [IW-1:0]       w_pre_idx;
    logic                w_dem_valid;
    logic                w_pre_valid;
    logic                w_use_dem;
    logic [NR_PORTS-1:0] w_win_gnt;
    logic [IW-1:0]       w_win_idx;
    logic                w_can_grant;
    logic                w_grant;
    refill_id_t          w_gid;
    refill_id_t          w_rid;
    logic [IW-1:0]       w_rsp_port;
    logic [NR_PORTS-1:0] w_rsp_hit;
    logic                w_rsp_port_rdy;
    logic                w_rsp_cnt_nz;
    logic                w_rsp_bad;
    logic [NR_PORTS-1:0] w_inc;
    logic [NR_PORTS-1:0] w_dec;
    logic                w_unused_id;

    // Eligibility: valid and below the per-port in-flight limit.
    always_comb begin
        w_elig = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            w_elig[p] = in_req_valid_i[p] && (r_cnt[p] < CW'(MAX_OUTSTANDING));
        end
    end

    assign w_dem_req = w_elig & ~in_req_prefetch_i;
    assign w_pre_req = w_elig & in_req_prefetch_i;

    snitch_icache_rr_pick #(
        .N  (NR_PORTS),
        .IW (IW)
    ) u_rr_dem (
        .req_i   (w_dem_req),
        .ptr_i   (r_dem_ptr),
        .gnt_o   (w_dem_gnt),
        .idx_o   (w_dem_idx),
        .valid_o (w_dem_valid)
    );

    snitch_icache_rr_pick #(
        .N  (NR_PORTS),
        .IW (IW)
    ) u_rr_pre (
        .req_i   (w_pre_req),
        .ptr_i   (r_pre_ptr),
        .gnt_o   (w_pre_gnt),
        .idx_o   (w_pre_idx),
        .valid_o (w_pre_valid)
    );

    // Any demand request beats every prefetch request.
    assign w_use_dem = w_dem_valid;
    assign w_win_gnt = w_use_dem ? w_dem_gnt : w_pre_gnt;
    assign w_win_idx = w_use_dem ? w_dem_idx : w_pre_idx;

    // Grant only into an empty stage or one that drains this cycle; reset
    // masks the ready path because the stage already reads empty then.
    assign w_can_grant    = !rst_i && ((r_state == StEmpty) || out_req_ready_i);
    assign w_grant        = w_can_grant && (w_dem_valid || w_pre_valid);
    assign in_req_ready_o = w_grant ? w_win_gnt : '0;
    assign w_inc          = in_req_valid_i & in_req_ready_o;

    // Build the outgoing ID from the winner.
    always_comb begin
        w_gid          = '0;
        w_gid.port     = ID_PORT_W'(w_win_idx);
        w_gid.prefetch = !w_use_dem;
    end

    // Output stage: load on grant, empty on drain without a refill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StEmpty;
            r_addr  <= '0;
            r_id    <= '0;
        end else begin
            unique case (r_state)
                StEmpty: if (w_grant) r_state <= StFull;
                StFull:  if (out_req_ready_i && !w_grant) r_state <= StEmpty;
                default: r_state <= StEmpty;
            endcase
            if (w_grant) begin
                r_addr <= in_req_addr_i[w_win_idx];
                r_id   <= {w_gid.port[IW-1:0], w_gid.prefetch};
            end
        end
    end

    assign out_req_valid_o = (r_state == StFull);
    assign out_req_addr_o  = r_addr;
    assign out_req_id_o    = r_id;

    // Remember the last winner of each class.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dem_ptr <= '0;
            r_pre_ptr <= '0;
        end else if (w_grant) begin
            if (w_use_dem) r_dem_ptr <= w_dem_idx;
            else           r_pre_ptr <= w_pre_idx;
        end
    end

    // Response decode: ID upper bits select the port.
    assign w_rid      = {ID_PORT_W'(out_rsp_id_i[IDW-1:1]), out_rsp_id_i[0]};
    assign w_rsp_port = w_rid.port[IW-1:0];

    // Look up the addressed port; an index outside the port range hits nothing.
    always_comb begin
        w_rsp_hit      = '0;
        w_rsp_port_rdy = 1'b0;
        w_rsp_cnt_nz   = 1'b0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (w_rsp_port == IW'(p)) begin
                w_rsp_hit[p]   = 1'b1;
                w_rsp_port_rdy = in_rsp_ready_i[p];
                w_rsp_cnt_nz   = (r_cnt[p] != '0);
            end
        end
    end

    // Nothing in flight for that port (or no such port): swallow the beat.
    assign w_rsp_bad       = !(|w_rsp_hit) || !w_rsp_cnt_nz;
    assign in_rsp_valid_o  = (out_rsp_valid_i && !w_rsp_bad) ? w_rsp_hit : '0;
    assign out_rsp_ready_o = w_rsp_bad ? 1'b1 : w_rsp_port_rdy;
    assign misroute_o      = !rst_i && out_rsp_valid_i && w_rsp_bad;
    assign in_rsp_data_o   = out_rsp_data_i;
    assign in_rsp_error_o  = out_rsp_error_i;
    assign w_dec = (out_rsp_valid_i && !w_rsp_bad && w_rsp_port_rdy) ? w_rsp_hit : '0;

    // In-flight counters: +1 on grant, -1 on routed response, both cancel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (w_inc[p] && !w_dec[p]) begin
                    r_cnt[p] <= r_cnt[p] + CW'(1);
                end else if (w_dec[p] && !w_inc[p]) begin
                    r_cnt[p] <= r_cnt[p] - CW'(1);
                end
            end
        end
    end

    assign w_unused_id = ^{w_gid.port[ID_PORT_W-1:IW], w_rid.port[ID_PORT_W-1:IW],
                           w_rid.prefetch};

`ifdef SNITCH_ICACHE_ARB_PERF_EN
    logic [31:0] r_perf_dem;
    logic [31:0] r_perf_pre;
    logic [31:0] r_perf_conf;
    logic        w_conflict;

    // Two or more eligible ports: clearing the lowest set bit leaves some.
    assign w_conflict = ((w_elig & (w_elig - 1'b1)) != '0);

    // Saturating event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_dem  <= '0;
            r_perf_pre  <= '0;
            r_perf_conf <= '0;
        end else begin
            if (w_grant && w_use_dem && (r_perf_dem != '1))   r_perf_dem  <= r_perf_dem + 32'd1;
            if (w_grant && !w_use_dem && (r_perf_pre != '1))  r_perf_pre  <= r_perf_pre + 32'd1;
            if (w_conflict && (r_perf_conf != '1))            r_perf_conf <= r_perf_conf + 32'd1;
        end
    end

    assign perf_demand_o   = r_perf_dem;
    assign perf_prefetch_o = r_perf_pre;
    assign perf_conflict_o = r_perf_conf;
`else
    assign perf_demand_o   = '0;
    assign perf_prefetch_o = '0;
    assign perf_conflict_o = '0;
`endif

    // Ready is one-hot0 and a stalled request holds its payload.
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(in_req_ready_o));
    a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_req_valid_o && !out_req_ready_i) |=>
        (out_req_valid_o && $stable(out_req_addr_o) && $stable(out_req_id_o)));

endmodule
